noc_port_adapter: RTL and testbench

Parametrised bridge between one CPU-side IP core and one circulant-NoC router injection/ejection port. It succeeds the fixed 32-bit/17-bit converter: node count, address, payload and FIFO depth are generic. It adds valid/ready handshaking on the CPU side, TX and RX FIFOs, local loopback, destination checking and a drop counter. It sits between `sm_cpu`-class cores and the router's `in_free`/`out_data` pair.

---
 rtl/noc_port_adapter.sv | 154 +++++++++++++++
 tb/tb_noc_port_adapter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_port_adapter.sv
// rtl/noc_port_adapter.sv - CPU valid/ready bridge to one circulant-NoC router port
// TX/RX FIFOs, inject FSM with a mandatory gap cycle, local loopback, dest check, drop counter.
module noc_port_adapter #(
  parameter int NODES   = 9,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int CPU_W   = 32,
  parameter int DEPTH   = 4,
  parameter int NODE_ID = 9,
  localparam int FLIT_W = 1 + 2*ADDR_W + DATA_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_tx_valid,
  output logic              cpu_tx_ready,
  input  logic [CPU_W-1:0]  cpu_tx_data,
  output logic              cpu_rx_valid,
  input  logic              cpu_rx_ready,
  output logic [CPU_W-1:0]  cpu_rx_data,
  output logic [FLIT_W-1:0] to_r,
  input  logic              r_busy,
  input  logic [FLIT_W-1:0] from_r,
  output logic [ADDR_W-1:0] r_name,
  output logic              err_dest,
  output logic [7:0]        rx_drop_cnt,
  output logic [LVL_W-1:0]  tx_level,
  output logic [LVL_W-1:0]  rx_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] MY_ID   = ADDR_W'(NODE_ID);
  localparam logic [ADDR_W:0]   NODES_W = (ADDR_W+1)'(NODES);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;

  logic [1:0]        state;
  logic              ready_en;
  logic [ENT_W-1:0]  tx_mem [DEPTH];
  logic [ENT_W-1:0]  rx_mem [DEPTH];
  logic [PTR_W-1:0]  tx_wr, tx_rd, rx_wr, rx_rd;
  logic              tx_empty, tx_full, rx_empty;
  logic [ENT_W-1:0]  tx_head;
  logic [ADDR_W-1:0] head_dest, in_dest;
  logic [DATA_W-1:0] head_pl;
  logic              dest_bad, tx_hs, tx_push, tx_pop;
  logic              lb_full, lb_take, lb_write;
  logic [ENT_W-1:0]  lb_data;
  logic              fr_valid, rx_can, rx_push, rx_pop;
  logic [ENT_W-1:0]  rx_wdata;
  logic              unused_bits;

  assign r_name    = MY_ID;
  assign tx_empty  = (tx_level == '0);
  assign tx_full   = (tx_level == FULL_LVL);
  assign rx_empty  = (rx_level == '0);
  assign tx_head   = tx_mem[tx_rd];
  assign head_dest = tx_head[ENT_W-1:DATA_W];
  assign head_pl   = tx_head[DATA_W-1:0];
  assign in_dest   = cpu_tx_data[ENT_W-1:DATA_W];
  // Own address is always deliverable through loopback, even when it lies outside 0..NODES-1.
  assign dest_bad  = ({1'b0, in_dest} >= NODES_W) && (in_dest != MY_ID);

  assign cpu_tx_ready = ready_en && !tx_full;
  assign tx_hs        = cpu_tx_valid && cpu_tx_ready;
  assign tx_push      = tx_hs && !dest_bad;

  assign fr_valid     = from_r[FLIT_W-1];
  assign cpu_rx_valid = !rx_empty;
  assign cpu_rx_data  = rx_empty ? '0 : CPU_W'(rx_mem[rx_rd]);
  assign rx_pop       = cpu_rx_valid && cpu_rx_ready;
  assign rx_can       = (rx_level < FULL_LVL) || rx_pop;
  assign lb_write     = lb_full && !fr_valid && rx_can;
  assign rx_push      = (fr_valid && rx_can) || lb_write;
  assign rx_wdata     = fr_valid ? from_r[ENT_W-1:0] : lb_data;
  assign unused_bits  = ^{cpu_tx_data, from_r};

  always_comb begin
    tx_pop  = 1'b0;
    lb_take = 1'b0;
    case (state)
      IDLE: if (!tx_empty && head_dest == MY_ID && !lb_full) begin
        tx_pop  = 1'b1;
        lb_take = 1'b1;
      end
      SEND: tx_pop = !r_busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      to_r  <= '0;
    end else begin
      case (state)
        IDLE: if (!tx_empty && head_dest != MY_ID) begin
          to_r  <= {1'b1, head_dest, MY_ID, head_pl};
          state <= SEND;
        end
        SEND: if (!r_busy) begin
          to_r  <= '0;
          state <= GAP;
        end
        GAP: state <= IDLE;
        default: begin
          state <= IDLE;
          to_r  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= cpu_tx_data[ENT_W-1:0];
    if (rx_push) rx_mem[rx_wr] <= rx_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      err_dest    <= 1'b0;
      tx_wr       <= '0;
      tx_rd       <= '0;
      tx_level    <= '0;
      rx_wr       <= '0;
      rx_rd       <= '0;
      rx_level    <= '0;
      lb_full     <= 1'b0;
      lb_data     <= '0;
      rx_drop_cnt <= '0;
    end else begin
      ready_en <= 1'b1;
      err_dest <= tx_hs && dest_bad;
      if (tx_push) tx_wr <= tx_wr + PTR_W'(1);
      if (tx_pop)  tx_rd <= tx_rd + PTR_W'(1);
      if (tx_push && !tx_pop)      tx_level <= tx_level + LVL_W'(1);
      else if (!tx_push && tx_pop) tx_level <= tx_level - LVL_W'(1);
      if (rx_push) rx_wr <= rx_wr + PTR_W'(1);
      if (rx_pop)  rx_rd <= rx_rd + PTR_W'(1);
      if (rx_push && !rx_pop)      rx_level <= rx_level + LVL_W'(1);
      else if (!rx_push && rx_pop) rx_level <= rx_level - LVL_W'(1);
      // Loopback words are staged one cycle so they can yield to router traffic.
      if (lb_take) begin
        lb_full <= 1'b1;
        lb_data <= {MY_ID, head_pl};
      end else if (lb_write) begin
        lb_full <= 1'b0;
      end
      if (fr_valid && !rx_can && rx_drop_cnt != 8'hFF)
        rx_drop_cnt <= rx_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_noc_port_adapter.sv
// tb/tb_noc_port_adapter.sv - directed self-checking bench for noc_port_adapter
module tb_noc_port_adapter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_tx_valid;
  logic        cpu_tx_ready;
  logic [31:0] cpu_tx_data;
  logic        cpu_rx_valid;
  logic        cpu_rx_ready;
  logic [31:0] cpu_rx_data;
  logic [16:0] to_r;
  logic        r_busy;
  logic [16:0] from_r;
  logic [3:0]  r_name;
  logic        err_dest;
  logic [7:0]  rx_drop_cnt;
  logic [2:0]  tx_level;
  logic [2:0]  rx_level;

  int checks = 0;
  int failures = 0;
  logic [16:0] flits[$];
  logic        prev_v = 1'b0;

  noc_port_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_tx_valid(cpu_tx_valid), .cpu_tx_ready(cpu_tx_ready), .cpu_tx_data(cpu_tx_data),
    .cpu_rx_valid(cpu_rx_valid), .cpu_rx_ready(cpu_rx_ready), .cpu_rx_data(cpu_rx_data),
    .to_r(to_r), .r_busy(r_busy), .from_r(from_r), .r_name(r_name),
    .err_dest(err_dest), .rx_drop_cnt(rx_drop_cnt),
    .tx_level(tx_level), .rx_level(rx_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (to_r[16] && !prev_v) flits.push_back(to_r);
    prev_v = to_r[16];
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        hs;
    logic        got;
    logic [16:0] exp_flit;
    logic [31:0] rx_exp [4];

    rst_n = 1'b0; cpu_tx_valid = 1'b0; cpu_tx_data = '0; cpu_rx_ready = 1'b0;
    r_busy = 1'b0; from_r = '0;
    step(); step();
    check("rst_to_r", 32'(to_r), 32'h0);
    check("rst_tx_ready", 32'(cpu_tx_ready), 32'h0);
    check("rst_rx_valid", 32'(cpu_rx_valid), 32'h0);
    check("rst_rx_data", cpu_rx_data, 32'h0);
    check("rst_err", 32'(err_dest), 32'h0);
    check("rst_drop", 32'(rx_drop_cnt), 32'h0);
    check("rst_tx_lvl", 32'(tx_level), 32'h0);
    check("rst_rx_lvl", 32'(rx_level), 32'h0);
    check("r_name", 32'(r_name), 32'h9);
    rst_n = 1'b1;
    step();
    check("rel_tx_ready", 32'(cpu_tx_ready), 32'h1);

    // single flit, dest 3 payload A5
    cpu_tx_valid = 1'b1; cpu_tx_data = 32'h3A5;
    step();
    cpu_tx_valid = 1'b0;
    check("t1_lvl1", 32'(tx_level), 32'h1);
    check("t1_to_r_pre", 32'(to_r), 32'h0);
    step();
    check("t1_to_r", 32'(to_r), 32'h139A5);
    step();
    check("t1_to_r_off", 32'(to_r), 32'h0);
    check("t1_lvl0", 32'(tx_level), 32'h0);
    step();
    check("t1_gap", 32'(to_r), 32'h0);

    // hold in SEND under r_busy
    r_busy = 1'b1;
    cpu_tx_valid = 1'b1; cpu_tx_data = 32'h511;
    step();
    cpu_tx_valid = 1'b0;
    step();
    check("t2_send", 32'(to_r), 32'h15911);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold", 32'(to_r), 32'h15911);
    end
    check("t2_lvl_hold", 32'(tx_level), 32'h1);
    r_busy = 1'b0;
    step();
    check("t2_pop_to_r", 32'(to_r), 32'h0);
    check("t2_pop_lvl", 32'(tx_level), 32'h0);
    step();
    check("t2_gap", 32'(to_r), 32'h0);

    // overfill TX while router busy
    flits.delete();
    r_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_tx_valid = 1'b1;
      cpu_tx_data = 32'((i + 1) * 256 + 32 + i);
      check("t3_rdy", 32'(cpu_tx_ready), 32'h1);
      step();
    end
    cpu_tx_data = 32'h524;
    check("t3_full_rdy", 32'(cpu_tx_ready), 32'h0);
    check("t3_full_lvl", 32'(tx_level), 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_blocked_lvl", 32'(tx_level), 32'h4);
    end
    r_busy = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      hs = cpu_tx_ready;
      step();
      if (hs) got = 1'b1;
    end
    check("t3_fifth_accept", 32'(got), 32'h1);
    cpu_tx_valid = 1'b0;
    repeat (20) step();
    check("t3_nflits", 32'(flits.size()), 32'h5);
    for (int i = 0; i < 5; i++) begin
      exp_flit = {1'b1, 4'(i + 1), 4'd9, 8'(32 + i)};
      check("t3_order", (i < flits.size()) ? 32'(flits[i]) : 32'hDEAD, 32'(exp_flit));
    end

    // bad destination, then loopback
    flits.delete();
    cpu_tx_valid = 1'b1; cpu_tx_data = 32'hC77;
    step();
    cpu_tx_valid = 1'b0;
    check("t4_err_pulse", 32'(err_dest), 32'h1);
    check("t4_err_lvl", 32'(tx_level), 32'h0);
    cpu_tx_valid = 1'b1; cpu_tx_data = 32'h93C;
    step();
    cpu_tx_valid = 1'b0;
    check("t4_err_end", 32'(err_dest), 32'h0);
    check("t4_lb_lvl", 32'(tx_level), 32'h1);
    check("t4_rx_early0", 32'(cpu_rx_valid), 32'h0);
    step();
    check("t4_rx_early1", 32'(cpu_rx_valid), 32'h0);
    step();
    check("t4_rx_valid", 32'(cpu_rx_valid), 32'h1);
    check("t4_rx_data", cpu_rx_data, 32'h93C);
    check("t4_to_r", 32'(to_r), 32'h0);
    cpu_rx_ready = 1'b1;
    step();
    cpu_rx_ready = 1'b0;
    check("t4_rx_lvl", 32'(rx_level), 32'h0);
    check("t4_no_flit", 32'(flits.size()), 32'h0);

    // RX overflow and pop-while-full
    for (int i = 0; i < 6; i++) begin
      from_r = {1'b1, 4'd7, 4'(i), 8'(80 + i)};
      step();
    end
    from_r = '0;
    check("t5_lvl", 32'(rx_level), 32'h4);
    check("t5_drop", 32'(rx_drop_cnt), 32'h2);
    check("t5_head", cpu_rx_data, 32'h050);
    from_r = {1'b1, 4'd7, 4'd6, 8'h56};
    cpu_rx_ready = 1'b1;
    step();
    from_r = '0;
    cpu_rx_ready = 1'b0;
    check("t5_full_lvl", 32'(rx_level), 32'h4);
    check("t5_full_drop", 32'(rx_drop_cnt), 32'h2);
    rx_exp[0] = 32'h151; rx_exp[1] = 32'h252; rx_exp[2] = 32'h353; rx_exp[3] = 32'h656;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain", cpu_rx_data, rx_exp[i]);
      cpu_rx_ready = 1'b1;
      step();
      cpu_rx_ready = 1'b0;
    end
    check("t5_empty", 32'(cpu_rx_valid), 32'h0);

    // reset in SEND with both FIFOs holding 3
    r_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_tx_valid = 1'b1;
      cpu_tx_data = 32'(512 + i);
      from_r = {1'b1, 4'd7, 4'(i), 8'(96 + i)};
      step();
    end
    cpu_tx_valid = 1'b0;
    from_r = '0;
    check("t6_tx_lvl", 32'(tx_level), 32'h3);
    check("t6_rx_lvl", 32'(rx_level), 32'h3);
    check("t6_sending", 32'(to_r[16]), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    flits.delete();
    check("t6_to_r", 32'(to_r), 32'h0);
    check("t6_tx_ready", 32'(cpu_tx_ready), 32'h0);
    check("t6_rx_valid", 32'(cpu_rx_valid), 32'h0);
    check("t6_rx_data", cpu_rx_data, 32'h0);
    check("t6_err", 32'(err_dest), 32'h0);
    check("t6_drop", 32'(rx_drop_cnt), 32'h0);
    check("t6_tx_lvl0", 32'(tx_level), 32'h0);
    check("t6_rx_lvl0", 32'(rx_level), 32'h0);
    step();
    check("t6_ready_up", 32'(cpu_tx_ready), 32'h1);
    r_busy = 1'b0;
    repeat (6) step();
    check("t6_no_replay", 32'(flits.size()), 32'h0);
    check("t6_to_r_idle", 32'(to_r), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
